// File: rtl/cceip_kernel_ctrl.sv
// ---------------------------------------------------------------------------
// cceip_kernel_ctrl
//
// Host-side kernel control block. It accepts an ap_start rising edge, fans a
// one-cycle start pulse out to the enabled engine channels, collects their
// one-cycle completion pulses and reports idle/done/ready back to the host.
// It supports the ap_ctrl_hs protocol (CHAIN_MODE=0) and the ap_ctrl_chain
// protocol (CHAIN_MODE=1).
//
// Parameters:
//   NUM_CH      number of engine channels (1..16)
//   CHAIN_MODE  0 = ap_ctrl_hs, 1 = ap_ctrl_chain (DONE held until ap_continue)
//
// Ports:
//   ap_clk       in   kernel clock
//   areset       in   synchronous active-high reset
//   ap_start     in   host start request, rising-edge sensitive
//   ap_continue  in   host acknowledge of done (CHAIN_MODE=1 only)
//   ap_idle      out  controller is in IDLE
//   ap_done      out  controller is in DONE
//   ap_ready     out  one-cycle pulse in the first DONE cycle
//   ch_en        in   per-channel enable mask, sampled when a start is accepted
//   ch_start     out  per-channel one-cycle start pulse
//   ch_done      in   per-channel one-cycle completion pulse
//   ch_active    out  channel started and not yet done
//   run_cycles   out  run duration in ap_clk cycles (only with the macro)
//
// Optional feature macro: CCEIP_KCTRL_CYCLE_CNT_EN
//   When defined, adds the 64-bit saturating run_cycles counter and port.
// ---------------------------------------------------------------------------
module cceip_kernel_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int CHAIN_MODE = 0
) (
  input  logic              ap_clk,
  input  logic              areset,
  input  logic              ap_start,
  input  logic              ap_continue,
  output logic              ap_idle,
  output logic              ap_done,
  output logic              ap_ready,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] ch_start,
  input  logic [NUM_CH-1:0] ch_done,
  output logic [NUM_CH-1:0] ch_active
`ifdef CCEIP_KCTRL_CYCLE_CNT_EN
  ,
  output logic [63:0]       run_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic                ap_start_r;
  logic                start_pulse;
  logic                accept;
  logic                all_done;
  logic                ready_reg;
  logic [NUM_CH-1:0]   en_q;
  logic [NUM_CH-1:0]   done_r;
  logic [NUM_CH-1:0]   ch_start_reg;

  assign start_pulse = ap_start & ~ap_start_r;
  // Disabled channels count as already finished.
  assign all_done    = &(done_r | ~en_q);

  // Next-state and status outputs.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        // Edges seen in RUN/DONE are simply dropped; only IDLE accepts.
        if (start_pulse) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (all_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if ((CHAIN_MODE == 0) || ap_continue) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    ap_idle   = (state_reg == IDLE);
    ap_done   = (state_reg == DONE);
    ap_ready  = ready_reg;
    ch_start  = ch_start_reg;
    ch_active = (state_reg == RUN) ? (en_q & ~done_r) : '0;
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_reg    <= IDLE;
      // Reset high so an ap_start held across reset is not seen as an edge.
      ap_start_r   <= 1'b1;
      en_q         <= '0;
      done_r       <= '0;
      ch_start_reg <= '0;
      ready_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ap_start_r <= ap_start;
      if (accept) begin
        en_q   <= ch_en;
        done_r <= '0;
      end else if (state_reg == RUN) begin
        // Includes the ch_start cycle itself, so a same-cycle done counts.
        done_r <= done_r | (ch_done & en_q);
      end
      ch_start_reg <= accept ? ch_en : '0;
      ready_reg    <= (state_reg == RUN) && (state_next == DONE);
    end
  end

`ifdef CCEIP_KCTRL_CYCLE_CNT_EN
  logic [63:0] run_cycles_reg;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      run_cycles_reg <= '0;
    end else if (accept) begin
      run_cycles_reg <= '0;
    end else if ((state_reg == RUN) && !(&run_cycles_reg)) begin
      run_cycles_reg <= run_cycles_reg + 64'd1;
    end
  end

  assign run_cycles = run_cycles_reg;
`endif

endmodule

// File: tb/tb_cceip_kernel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cceip_kernel_ctrl
//
// Directed bench for cceip_kernel_ctrl. Two instances: "dut" in ap_ctrl_hs
// mode and "dut_chain" in ap_ctrl_chain mode, sharing clock and reset.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// Cycle c below means "c edges after the edge that accepted the start".
// ---------------------------------------------------------------------------
module tb_cceip_kernel_ctrl;

  localparam int NUM_CH = 4;

  logic              ap_clk = 1'b0;
  logic              areset;

  logic              ap_start, ap_continue;
  logic              ap_idle, ap_done, ap_ready;
  logic [NUM_CH-1:0] ch_en, ch_start, ch_done, ch_active;

  logic              c_ap_start, c_ap_continue;
  logic              c_ap_idle, c_ap_done, c_ap_ready;
  logic [NUM_CH-1:0] c_ch_en, c_ch_start, c_ch_done, c_ch_active;

`ifdef CCEIP_KCTRL_CYCLE_CNT_EN
  logic [63:0]       run_cycles, c_run_cycles;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 ap_clk = ~ap_clk;

  cceip_kernel_ctrl #(.NUM_CH(NUM_CH), .CHAIN_MODE(0)) dut (
    .ap_clk      (ap_clk),
    .areset      (areset),
    .ap_start    (ap_start),
    .ap_continue (ap_continue),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .ap_ready    (ap_ready),
    .ch_en       (ch_en),
    .ch_start    (ch_start),
    .ch_done     (ch_done),
    .ch_active   (ch_active)
`ifdef CCEIP_KCTRL_CYCLE_CNT_EN
    ,
    .run_cycles  (run_cycles)
`endif
  );

  cceip_kernel_ctrl #(.NUM_CH(NUM_CH), .CHAIN_MODE(1)) dut_chain (
    .ap_clk      (ap_clk),
    .areset      (areset),
    .ap_start    (c_ap_start),
    .ap_continue (c_ap_continue),
    .ap_idle     (c_ap_idle),
    .ap_done     (c_ap_done),
    .ap_ready    (c_ap_ready),
    .ch_en       (c_ch_en),
    .ch_start    (c_ch_start),
    .ch_done     (c_ch_done),
    .ch_active   (c_ch_active)
`ifdef CCEIP_KCTRL_CYCLE_CNT_EN
    ,
    .run_cycles  (c_run_cycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("[TB] ok %s = %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    logic [NUM_CH-1:0] exp_act;

    areset = 1'b1;
    ap_start = 1'b1;          // held high across reset: must not start a run
    ap_continue = 1'b0;
    ch_en = '0;
    ch_done = '0;
    c_ap_start = 1'b1;
    c_ap_continue = 1'b0;
    c_ch_en = '0;
    c_ch_done = '0;

    // ---------------- reset state ----------------
    step(); step();
    check("rst_idle", ap_idle, 1);
    check("rst_done", ap_done, 0);
    check("rst_ready", ap_ready, 0);
    check("rst_ch_start", ch_start, 0);
    check("rst_ch_active", ch_active, 0);
`ifdef CCEIP_KCTRL_CYCLE_CNT_EN
    check("rst_run_cycles", run_cycles, 0);
`endif
    areset = 1'b0;
    ch_en = 4'hF;
    step(); step(); step();
    check("held_start_idle", ap_idle, 1);
    check("held_start_ch_start", ch_start, 0);
    check("held_start_chain_idle", c_ap_idle, 1);
    ap_start = 1'b0;
    c_ap_start = 1'b0;
    step();

    // ---------------- all four channels, staggered done ----------------
    ap_start = 1'b1;
    ch_en = 4'hF;
    step();
    ap_start = 1'b0;
    ch_en = 4'h0;               // mask was latched at acceptance
    for (int c = 1; c <= 12; c++) begin
      exp_act = 4'hF;
      if (c > 3) exp_act[0] = 1'b0;
      if (c > 5) exp_act[1] = 1'b0;
      if (c > 7) exp_act[2] = 1'b0;
      if (c > 9) exp_act[3] = 1'b0;
      if (c > 10) exp_act = '0;
      check("t1_ch_start", ch_start, (c == 1) ? 4'hF : 4'h0);
      check("t1_ap_done", ap_done, (c == 11) ? 1 : 0);
      check("t1_ap_ready", ap_ready, (c == 11) ? 1 : 0);
      check("t1_ap_idle", ap_idle, (c >= 12) ? 1 : 0);
      check("t1_ch_active", ch_active, exp_act);
`ifdef CCEIP_KCTRL_CYCLE_CNT_EN
      if (c == 11) check("t1_run_cycles", run_cycles, 10);
      if (c == 12) check("t1_run_cycles_hold", run_cycles, 10);
`endif
      ch_done = (c == 3) ? 4'h1 : (c == 5) ? 4'h2 : (c == 7) ? 4'h4 : (c == 9) ? 4'h8 : 4'h0;
      step();
    end
    ch_done = '0;

    // ---------------- disabled-channel done ignored ----------------
    ap_start = 1'b1;
    ch_en = 4'b0101;
    step();
    ap_start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check("t2_ch_start", ch_start, (c == 1) ? 4'b0101 : 4'b0000);
      check("t2_ch_active", ch_active, (c <= 4) ? 4'b0101 : 4'b0000);
      check("t2_ap_done", ap_done, (c == 6) ? 1 : 0);
      check("t2_ap_idle", ap_idle, (c == 7) ? 1 : 0);
      ch_done = (c == 2) ? 4'b1010 : (c == 4) ? 4'b0101 : 4'b0000;
      step();
    end
    ch_done = '0;

    // ---------------- empty mask + edge on DONE->IDLE cycle ----------------
    ap_start = 1'b1;
    ch_en = 4'b0000;
    step();
    ap_start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check("t3_ch_start", ch_start, 0);
      check("t3_ap_done", ap_done, (c == 2) ? 1 : 0);
      check("t3_ap_ready", ap_ready, (c == 2) ? 1 : 0);
      check("t3_ap_idle", ap_idle, (c >= 3) ? 1 : 0);
`ifdef CCEIP_KCTRL_CYCLE_CNT_EN
      if (c == 2) check("t3_run_cycles", run_cycles, 1);
`endif
      if (c == 2) ap_start = 1'b1;   // edge lands on the DONE->IDLE edge
      step();
    end
    // A fresh edge is accepted; ch_done coincident with ch_start counts.
    ap_start = 1'b0;
    ch_en = 4'b0010;
    step();
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    check("t3b_ch_start", ch_start, 4'b0010);
    check("t3b_ap_idle", ap_idle, 0);
    ch_done = 4'b0010;
    step();
    ch_done = '0;
    check("t3b_ch_active", ch_active, 0);
    check("t3b_ap_done_c2", ap_done, 0);
    step();
    check("t3b_ap_done_c3", ap_done, 1);
    step();
    check("t3b_ap_idle_c4", ap_idle, 1);

    // ---------------- chain mode: DONE held until ap_continue ----------------
    c_ap_start = 1'b1;
    c_ch_en = 4'b0001;
    step();
    c_ap_start = 1'b0;
    c_ch_done = 4'b0001;       // same cycle as ch_start
    c_ap_continue = 1'b1;      // in RUN: must be ignored
    check("t4_ch_start", c_ch_start, 4'b0001);
    step();
    c_ch_done = '0;
    c_ap_continue = 1'b0;
    for (int c = 2; c <= 22; c++) begin
      check("t4_ap_done", c_ap_done, (c >= 3) ? 1 : 0);
      check("t4_ap_ready", c_ap_ready, (c == 3) ? 1 : 0);
      check("t4_ap_idle", c_ap_idle, 0);
      step();
    end
    check("t4_done_before_cont", c_ap_done, 1);
`ifdef CCEIP_KCTRL_CYCLE_CNT_EN
    check("t4_run_cycles", c_run_cycles, 2);
`endif
    c_ap_continue = 1'b1;
    step();
    c_ap_continue = 1'b0;
    check("t4_idle_after_cont", c_ap_idle, 1);
    check("t4_done_after_cont", c_ap_done, 0);

    // ---------------- second edge in RUN, then reset mid-RUN ----------------
    ap_start = 1'b1;
    ch_en = 4'b0011;
    step();
    check("t5_ch_start", ch_start, 4'b0011);
    ap_start = 1'b0;
    step();
    ap_start = 1'b1;           // second edge while running
    step();
    check("t5_second_edge_ch_start", ch_start, 0);
    check("t5_still_run", ap_idle, 0);
    check("t5_active", ch_active, 4'b0011);
    areset = 1'b1;             // ap_start held high through reset
    step();
    areset = 1'b0;
    check("t5_rst_idle", ap_idle, 1);
    check("t5_rst_active", ch_active, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("t5_post_rst_idle", ap_idle, 1);
      check("t5_post_rst_done", ap_done, 0);
      check("t5_post_rst_ch_start", ch_start, 0);
    end
    ap_start = 1'b0;
    step();
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    check("t5_restart_ch_start", ch_start, 4'b0011);
    check("t5_restart_idle", ap_idle, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cceip_kernel_ctrl.md
CCEIP_KERNEL_CTRL -- requirements
Module: cceip_kernel_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of engine channels (legal 1..16).
REQ-002 SHALL have parameter CHAIN_MODE, default 0, 0 = ap_ctrl_hs protocol, 1 = ap_ctrl_chain protocol.
REQ-003 SHALL have one clock and a synchronous, active-high reset: ap_clk  in  1  kernel clock; areset  in  1  synchronous active-high reset.
REQ-004 SHALL have ap_start  in  1  host start request, rising-edge sensitive.
REQ-005 SHALL have ap_continue  in  1  host acknowledge of done, used only when CHAIN_MODE=1.
REQ-006 SHALL have ap_idle / ap_done / ap_ready  out  1 each  host status.
REQ-007 SHALL have ch_en  in  NUM_CH  per-channel enable mask, sampled at start acceptance.
REQ-008 SHALL have ch_start  out  NUM_CH  per-channel one-cycle start pulse.
REQ-009 SHALL have ch_done  in  NUM_CH  per-channel one-cycle completion pulse.
REQ-010 SHALL have ch_active  out  NUM_CH  channel started and not yet done.
REQ-011 SHALL have run_cycles  out  64  run duration in ap_clk cycles (present only with the macro, see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE; ap_idle = (state==IDLE); ap_done = (state==DONE).
REQ-013 SHALL register ap_start into ap_start_r each cycle; start_pulse = ap_start & ~ap_start_r.
REQ-014 SHALL accept start_pulse only in IDLE, and ignore it in RUN/DONE (no queuing).
REQ-015 On acceptance, SHALL latch en_q <= ch_en, clear done_r, move to RUN, and drive ch_start = en_q for exactly the next cycle (1-cycle latency); ap_idle deasserts in that same cycle.
REQ-016 In RUN, SHALL update done_r <= done_r | (ch_done & en_q); ch_done on disabled channels, or outside RUN, SHALL be ignored.
REQ-017 A ch_done coincident with its ch_start cycle SHALL be counted.
REQ-018 all_done = &(done_r | ~en_q); in RUN, when all_done is true, the FSM SHALL move to DONE on the next edge.
REQ-019 With ch_en all zeros, the FSM SHALL pass through RUN for one cycle and then enter DONE; ch_start stays 0.
REQ-020 ap_ready SHALL be a one-cycle pulse in the first DONE cycle.
REQ-021 When CHAIN_MODE=0, DONE SHALL last exactly one cycle and then go to IDLE (ap_ready == ap_done).
REQ-022 When CHAIN_MODE=1, DONE SHALL hold until ap_continue=1 is sampled, then go to IDLE; ap_continue sampled outside DONE SHALL be ignored.
REQ-023 ch_active SHALL equal en_q & ~done_r in RUN and 0 otherwise.
REQ-024 A start_pulse arriving in the same cycle as the DONE->IDLE transition SHALL be ignored; the host must present a new edge.

Reset
REQ-025 On areset, SHALL force: state=IDLE, ap_idle=1, ap_done=0, ap_ready=0, ch_start=0, ch_active=0, en_q=0, done_r=0, run_cycles=0.
REQ-026 ap_start_r SHALL reset to 1, so that an ap_start held high across reset does not trigger a run.
REQ-027 Reset asserted mid-RUN SHALL abort the run; no ap_done is produced for the aborted run.

Configuration
REQ-028 Macro CCEIP_KCTRL_CYCLE_CNT_EN defined: run_cycles SHALL clear on start acceptance, increment every cycle in RUN, hold in DONE/IDLE, and saturate at all-ones.
REQ-029 Macro undefined: the run_cycles port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-030 NUM_CH=4, ch_en=4'b1111, ch_done pulses on ch0..ch3 at start+3/5/7/9 cycles -> ch_start=4'hF for 1 cycle, ap_done 1 cycle after the ch3 done, run_cycles=10, ap_idle=1 the next cycle.
REQ-031 ch_en=4'b0101, ch_done=4'b1010 pulsed, then 4'b0101 -> first pulse ignored, ap_done only after the second, ch_active=4'b0101 until then.
REQ-032 ch_en=0 -> ch_start stays 0, ap_done asserted 2 cycles after the start edge, ap_ready == ap_done.
REQ-033 CHAIN_MODE=1, ap_continue held 0 for 20 cycles then 1 -> ap_done held 20+ cycles, ap_ready 1 cycle only, IDLE the cycle after ap_continue is sampled.
REQ-034 Second ap_start edge during RUN, plus areset mid-RUN with ap_start held high -> second edge ignored; after reset: IDLE, no ap_done, no restart until ap_start falls and rises.
